// File: rtl/hss_rx_aligner.sv
// hss_rx_aligner: frame-sync word aligner with lock hysteresis and an N-lane slip gearbox.
// HSS_RX_PATTERN_CHECK_EN adds a per-lane incrementing-pattern checker on the aligned output.
module hss_rx_aligner #(
  parameter int N          = 3,
  parameter int W          = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         rxsync,
  input  logic [N*W-1:0]       rxdata,
  output logic [N*W-1:0]       dout,
  output logic                 dout_valid,
  output logic                 locked,
  output logic [$clog2(W)-1:0] shift,
  output logic [N-1:0]         err_flag,
  output logic [N*16-1:0]      err_cnt
);
  localparam int SW = $clog2(W);
  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;
  state_t         r_state;
  logic [7:0]     r_cnt;
  logic [7:0]     r_miss;
  logic [SW-1:0]  r_shift;
  logic [2*W-1:0] r_rxshift [N];
  logic [N*W-1:0] r_dout;
  logic           r_dout_valid;
  logic           w_valid;
  logic           w_good;
  logic [SW-1:0]  w_k;
  always_comb begin
    w_k = '0;
    for (int b = 0; b < W; b++) w_k = rxsync[b] ? SW'(b) : w_k;
  end
  assign w_valid = (rxsync != '0) && ((rxsync & (rxsync - W'(1))) == '0);
  assign w_good  = w_valid && (w_k == r_shift);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEARCH;
      r_cnt   <= '0;
      r_miss  <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        SEARCH: if (w_valid) begin
          r_shift <= w_k;
          r_cnt   <= 8'd1;
          r_state <= CONFIRM;
        end
        CONFIRM: if (w_good) begin
          r_cnt   <= r_cnt + 8'd1;
          r_state <= (r_cnt + 8'd1 == 8'(LOCK_CNT)) ? LOCKED : CONFIRM;
        end else begin
          r_cnt   <= '0;
          r_state <= SEARCH;
        end
        LOCKED: if (w_good) begin
          r_miss <= '0;
        end else if (r_miss + 8'd1 == 8'(UNLOCK_CNT)) begin
          r_miss  <= '0;
          r_cnt   <= '0;
          r_state <= SEARCH;
        end else begin
          r_miss <= r_miss + 8'd1;
        end
        default: r_state <= SEARCH;
      endcase
    end
  end
  // Gearbox keeps the previous and current word so any slip 0..W-1 is reachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_rxshift[i] <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_rxshift[i]        <= {rxdata[i*W +: W], r_rxshift[i][2*W-1:W]};
        r_dout[i*W +: W]    <= W'(r_rxshift[i] >> r_shift);
      end
      r_dout_valid <= (r_state == LOCKED);
    end
  end
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign locked     = (r_state == LOCKED);
  assign shift      = r_shift;
`ifdef HSS_RX_PATTERN_CHECK_EN
  logic [N*W-1:0]  r_dout_q;
  logic            r_dv_q;
  logic [N-1:0]    r_err_flag;
  logic [N*16-1:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_q   <= '0;
      r_dv_q     <= 1'b0;
      r_err_flag <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_dout_q <= r_dout;
      r_dv_q   <= r_dout_valid;
      for (int i = 0; i < N; i++) begin
        r_err_flag[i] <= r_dout_valid && r_dv_q && (r_dout[i*W +: W] != r_dout_q[i*W +: W] + W'(1));
        if (r_err_flag[i] && r_err_cnt[i*16 +: 16] != 16'hFFFF)
          r_err_cnt[i*16 +: 16] <= r_err_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
  assign err_flag = r_err_flag;
  assign err_cnt  = r_err_cnt;
`else
  assign err_flag = '0;
  assign err_cnt  = '0;
`endif
endmodule

// File: tb/tb_hss_rx_aligner.sv
// tb_hss_rx_aligner: table-driven lock/slip vectors with a data scoreboard for hss_rx_aligner.
module tb_hss_rx_aligner;
  localparam int N = 3;
  localparam int W = 8;
  typedef struct {
    logic       r;
    logic [7:0] sync;
    int         k;
    logic       lock;
    logic [2:0] sh;
  } vec_t;
  typedef struct {
    logic [N*W-1:0] d;
    logic [N-1:0]   m;
  } exp_t;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   rxsync = '0;
  logic [N*W-1:0] rxdata = '0;
  logic [N*W-1:0] dout;
  logic           dout_valid;
  logic           locked;
  logic [2:0]     shift;
  logic [N-1:0]   err_flag;
  logic [N*16-1:0] err_cnt;
  int   checks = 0;
  int   errors = 0;
  int   m = 1;
  logic skip_nxt = 1'b0;
  exp_t q[$];
  vec_t tv[$];
  hss_rx_aligner #(.N(N), .W(W), .LOCK_CNT(4), .UNLOCK_CNT(3)) dut (
    .clk(clk), .rst(rst), .rxsync(rxsync), .rxdata(rxdata), .dout(dout),
    .dout_valid(dout_valid), .locked(locked), .shift(shift),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] frame(int n, int lane);
    return 8'((n + 37 * lane) & 255);
  endfunction
  // Serial stream whose frames start k bits into each received word.
  function automatic logic [7:0] rxword(int n, int lane, int k);
    logic [15:0] t;
    t = {frame(n, lane), frame(n - 1, lane)};
    return 8'(t >> (8 - k));
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row_m=%0d got=%0h want=%0h", name, m, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [7:0] s, input int k, input logic l, input logic [2:0] sh);
    vec_t v;
    v.r = r; v.sync = s; v.k = k; v.lock = l; v.sh = sh;
    tv.push_back(v);
  endtask
  task automatic step(input logic r, input logic [7:0] s, input int k, input logic cor, input logic exp_dv);
    exp_t e;
    rst = r;
    rxsync = s;
    for (int i = 0; i < N; i++)
      rxdata[i*W +: W] = rxword(m, i, k) ^ ((cor && i == 1) ? 8'h55 : 8'h00);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      skip_nxt = 1'b0;
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        if (exp_dv)
          for (int i = 0; i < N; i++)
            if (e.m[i]) chk($sformatf("dout_lane%0d", i), 64'(dout[i*W +: W]), 64'(e.d[i*W +: W]));
      end
      for (int i = 0; i < N; i++) e.d[i*W +: W] = frame(m - 1, i);
      e.m = skip_nxt ? 3'b101 : 3'b111;
      skip_nxt = cor;
      q.push_back(e);
    end
    m++;
  endtask
  initial begin
    logic prev;
    int   pulses;
    int   other;
    add(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 8'h01, 0, i >= 3, 0);
    add(1, 8'h00, 5, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 8'h20, 5, i >= 3, 5);
    add(1, 8'h00, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 8'h01, 2, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 8'h04, 2, i >= 4, 2);
    add(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h01, 0, i >= 3, 0);
    add(0, 8'h00, 0, 1, 0);
    add(0, 8'h00, 0, 1, 0);
    add(0, 8'h01, 0, 1, 0);
    add(0, 8'h81, 0, 1, 0);
    add(0, 8'h81, 0, 1, 0);
    add(0, 8'h81, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 8'h01, 0, i >= 3, 0);
    add(1, 8'h01, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 8'h01, 0, i >= 3, 0);
    prev = 1'b0;
    foreach (tv[j]) begin
      step(tv[j].r, tv[j].sync, tv[j].k, 1'b0, prev);
      if (tv[j].r) begin
        chk("rst_locked", 64'(locked), 0);
        chk("rst_dout_valid", 64'(dout_valid), 0);
        chk("rst_shift", 64'(shift), 0);
        chk("rst_dout", 64'(dout), 0);
        chk("rst_err_flag", 64'(err_flag), 0);
        chk("rst_err_cnt", 64'(err_cnt), 0);
        prev = 1'b0;
      end else begin
        chk("locked", 64'(locked), 64'(tv[j].lock));
        chk("dout_valid", 64'(dout_valid), 64'(prev));
        if (tv[j].lock) chk("shift", 64'(shift), 64'(tv[j].sh));
        chk("err_flag_quiet", 64'(err_flag), 0);
        prev = tv[j].lock;
      end
    end
    pulses = 0;
    other = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h01, 0, i == 2, 1'b1);
      chk("chk_locked", 64'(locked), 1);
      chk("chk_dout_valid", 64'(dout_valid), 1);
      pulses += int'(err_flag[1]);
      other += int'(err_flag[0]) + int'(err_flag[2]);
    end
`ifdef HSS_RX_PATTERN_CHECK_EN
    chk("err_flag1_pulses", 64'(pulses), 2);
    chk("err_cnt", 64'(err_cnt), {16'd0, 16'd2, 16'd0});
`else
    chk("err_flag1_pulses", 64'(pulses), 0);
    chk("err_cnt", 64'(err_cnt), 0);
`endif
    chk("err_flag_other_lanes", 64'(other), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
